// File: rtl/fetch_queue_pkg.sv
// Shared core definitions for the fetch queue and its consumers.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    // Instruction decode injects when the queue has nothing valid (addi x0, x0, 0).
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_register_rst_en.sv
// Register with synchronous active-high reset and load enable.
module register_rst_en #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over enable; otherwise load d when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO with single-cycle flush and halt back-pressure.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fq_i_valid,
    input  logic [XLEN-1:0] fq_i_pc,
    input  logic [XLEN-1:0] fq_i_inst,
    output logic            fq_o_ready,
    output logic            fq_o_halt,
    input  logic            fq_i_flush,
    output logic            fq_o_valid,
    output logic [XLEN-1:0] fq_o_pc,
    output logic [XLEN-1:0] fq_o_inst,
    input  logic            fq_i_ready,
    output logic [$clog2(DEPTH):0] fq_o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [AW:0]   count, count_d;
    logic          push, pop;
    logic          wr_en, rd_en, count_en;
    fq_entry_t     mem [DEPTH];
    fq_entry_t     head;

    // Flush masks both handshakes so nothing enters or leaves that cycle;
    // a full queue never accepts, even if decode pops in the same cycle.
    assign fq_o_ready = (count != FULL) && !fq_i_flush;
    assign fq_o_halt  = !fq_o_ready;
    assign fq_o_valid = (count != '0) && !fq_i_flush;
    assign fq_o_count = count;

    assign push = fq_i_valid && fq_o_ready;
    assign pop  = fq_o_valid && fq_i_ready;

    assign head      = mem[rd_ptr];
    assign fq_o_pc   = head.pc;
    assign fq_o_inst = head.inst;

    assign wr_en    = push || fq_i_flush;
    assign rd_en    = pop  || fq_i_flush;
    assign count_en = push || pop || fq_i_flush;

    // Next pointer/count values with flush folded in as a clear.
    always_comb begin
        wr_ptr_d = fq_i_flush ? '0 : wr_ptr + AW'(1);
        rd_ptr_d = fq_i_flush ? '0 : rd_ptr + AW'(1);
        count_d  = count;
        if (fq_i_flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count - (AW+1)'(1);
        end
    end

    register_rst_en #(.WIDTH(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .d   (wr_ptr_d),
        .q   (wr_ptr)
    );

    register_rst_en #(.WIDTH(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .d   (rd_ptr_d),
        .q   (rd_ptr)
    );

    register_rst_en #(.WIDTH(AW+1)) u_count (
        .clk (clk),
        .rst (rst),
        .en  (count_en),
        .d   (count_d),
        .q   (count)
    );

    // Storage: cleared on reset so the head reads zero, written on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{pc: fq_i_pc, inst: fq_i_inst};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue: each row is one cycle, outputs
// are checked before the rising edge that consumes that row's inputs.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fq_i_valid;
    logic [31:0] fq_i_pc;
    logic [31:0] fq_i_inst;
    logic        fq_o_ready;
    logic        fq_o_halt;
    logic        fq_i_flush;
    logic        fq_o_valid;
    logic [31:0] fq_o_pc;
    logic [31:0] fq_o_inst;
    logic        fq_i_ready;
    logic [2:0]  fq_o_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [31:0] pc;
        logic        ready;
        logic        chk;
        logic [2:0]  e_count;
        logic        e_valid;
        logic        e_ready;
        logic        e_dchk;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fq_i_valid (fq_i_valid),
        .fq_i_pc    (fq_i_pc),
        .fq_i_inst  (fq_i_inst),
        .fq_o_ready (fq_o_ready),
        .fq_o_halt  (fq_o_halt),
        .fq_i_flush (fq_i_flush),
        .fq_o_valid (fq_o_valid),
        .fq_o_pc    (fq_o_pc),
        .fq_o_inst  (fq_o_inst),
        .fq_i_ready (fq_i_ready),
        .fq_o_count (fq_o_count)
    );

    always #5 clk = ~clk;

    // Instruction word paired with each PC: tag in the top nibble.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [31:0] pc, input logic rd,
                                input logic c, input logic [2:0] ec,
                                input logic ev, input logic er,
                                input logic ed, input logic [31:0] epc);
        vec_t t;
        t.rst = r; t.flush = f; t.valid = v; t.pc = pc; t.ready = rd;
        t.chk = c; t.e_count = ec; t.e_valid = ev; t.e_ready = er;
        t.e_dchk = ed; t.e_pc = epc;
        return t;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] pc, input logic rd);
        rst = r; fq_i_flush = f; fq_i_valid = v; fq_i_pc = pc;
        fq_i_inst = inst_of(pc); fq_i_ready = rd;
    endtask

    initial begin
        bit found;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        //             rst f  v  pc        rdy chk cnt v  r  dchk pc
        // reset then idle
        vecs.push_back(mk(1, 0, 0, 32'h000, 0, 0, 0, 0, 1, 0, 32'h000));
        vecs.push_back(mk(1, 0, 0, 32'h000, 0, 1, 0, 0, 1, 1, 32'h000));
        // fill four, fifth ignored while full
        vecs.push_back(mk(0, 0, 1, 32'h000, 0, 1, 0, 0, 1, 1, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h004, 0, 1, 1, 1, 1, 1, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h008, 0, 1, 2, 1, 1, 1, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h00C, 0, 1, 3, 1, 1, 1, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h010, 0, 1, 4, 1, 0, 1, 32'h000));
        // full with pop: no pass-through push
        vecs.push_back(mk(0, 0, 1, 32'h010, 1, 1, 4, 1, 0, 1, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 1, 1, 3, 1, 1, 1, 32'h004));
        vecs.push_back(mk(0, 0, 0, 32'h000, 1, 1, 2, 1, 1, 1, 32'h008));
        vecs.push_back(mk(0, 0, 0, 32'h000, 1, 1, 1, 1, 1, 1, 32'h00C));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 0, 0, 1, 0, 32'h000));
        // streaming across pointer wrap at count 1
        vecs.push_back(mk(0, 0, 1, 32'h020, 1, 1, 0, 0, 1, 0, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h024, 1, 1, 1, 1, 1, 1, 32'h020));
        vecs.push_back(mk(0, 0, 1, 32'h028, 1, 1, 1, 1, 1, 1, 32'h024));
        vecs.push_back(mk(0, 0, 1, 32'h02C, 1, 1, 1, 1, 1, 1, 32'h028));
        vecs.push_back(mk(0, 0, 1, 32'h030, 1, 1, 1, 1, 1, 1, 32'h02C));
        vecs.push_back(mk(0, 0, 1, 32'h034, 1, 1, 1, 1, 1, 1, 32'h030));
        vecs.push_back(mk(0, 0, 1, 32'h038, 1, 1, 1, 1, 1, 1, 32'h034));
        vecs.push_back(mk(0, 0, 1, 32'h03C, 1, 1, 1, 1, 1, 1, 32'h038));
        vecs.push_back(mk(0, 0, 1, 32'h040, 1, 1, 1, 1, 1, 1, 32'h03C));
        vecs.push_back(mk(0, 0, 1, 32'h044, 1, 1, 1, 1, 1, 1, 32'h040));
        vecs.push_back(mk(0, 0, 1, 32'h048, 1, 1, 1, 1, 1, 1, 32'h044));
        vecs.push_back(mk(0, 0, 0, 32'h000, 1, 1, 1, 1, 1, 1, 32'h048));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 0, 0, 1, 0, 32'h000));
        // no empty bypass
        vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 0, 0, 1, 0, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 1, 1, 1, 1, 32'h100));
        // flush at count 3 with push and pop attempted
        vecs.push_back(mk(0, 0, 1, 32'h104, 0, 1, 1, 1, 1, 1, 32'h100));
        vecs.push_back(mk(0, 0, 1, 32'h108, 0, 1, 2, 1, 1, 1, 32'h100));
        vecs.push_back(mk(0, 1, 1, 32'h10C, 1, 1, 3, 0, 0, 0, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 0, 0, 1, 0, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h200, 0, 1, 0, 0, 1, 0, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 1, 1, 1, 1, 32'h200));
        // reset mid-operation alongside flush and push
        vecs.push_back(mk(0, 0, 1, 32'h300, 0, 1, 1, 1, 1, 1, 32'h200));
        vecs.push_back(mk(1, 1, 1, 32'h304, 0, 1, 2, 0, 0, 0, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 0, 0, 1, 1, 32'h000));
        vecs.push_back(mk(0, 0, 1, 32'h400, 0, 1, 0, 0, 1, 0, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 1, 1, 1, 1, 1, 1, 32'h400));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 0, 0, 1, 0, 32'h000));
        // flush while empty
        vecs.push_back(mk(0, 1, 1, 32'h500, 0, 1, 0, 0, 0, 0, 32'h000));
        vecs.push_back(mk(0, 0, 0, 32'h000, 0, 1, 0, 0, 1, 0, 32'h000));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].pc, vecs[i].ready);
            #1;
            if (vecs[i].chk) begin
                check("count", i, 32'(fq_o_count), 32'(vecs[i].e_count));
                check("valid", i, 32'(fq_o_valid), 32'(vecs[i].e_valid));
                check("ready", i, 32'(fq_o_ready), 32'(vecs[i].e_ready));
                check("halt",  i, 32'(fq_o_halt),  32'(!vecs[i].e_ready));
                if (vecs[i].e_dchk) begin
                    check("pc", i, fq_o_pc, vecs[i].e_pc);
                    check("inst", i, fq_o_inst,
                          vecs[i].e_valid ? inst_of(vecs[i].e_pc) : 32'h0);
                end
            end
        end

        // Hand sequence: one push, then wait (bounded) for it to surface.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h600, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 5 && !found; n++) begin
            #1;
            if (fq_o_valid) found = 1'b1;
            else @(negedge clk);
        end
        check("wait_valid", 1000, 32'(found), 32'd1);
        check("wait_pc", 1000, fq_o_pc, 32'h600);
        check("wait_inst", 1000, fq_o_inst, inst_of(32'h600));
        // Decode ready must not mask valid; pop then confirm empty.
        fq_i_ready = 1'b1;
        #1;
        check("valid_ind_ready", 1001, 32'(fq_o_valid), 32'd1);
        @(negedge clk);
        fq_i_ready = 1'b0;
        #1;
        check("drained_count", 1002, 32'(fq_o_count), 32'd0);
        check("drained_valid", 1002, 32'(fq_o_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
